bip_control_unit_v2: RTL
========================

Name: bip_control_unit_v2

Overview:
Parametrised second-generation control unit for the BIP processor. It owns the program counter, fetches one instruction per cycle into a registered instruction register (IR) and decodes the IR into datapath control signals. Over the first-generation unit it adds conditional and unconditional branches with flush, a HALTED state with resume, a stall input, and configurable PC and instruction widths. It sits between program memory, which is read combinationally at PC, and the accumulator/ALU/data-RAM datapath.

Parameters:
INSTR_W, 16, instruction width; opcode is INSTR_W-1:INSTR_W-5 (fixed 5 bits), operand is the low OPERAND_W = INSTR_W-5 bits.
PC_W, 11, program counter width; must be <= OPERAND_W.
RESET_VECTOR, 0, PC value after reset.

Ports:
CLK  in  1  clock, rising edge.
RESET  in  1  asynchronous, active-high reset.
INSTRUCTION  in  INSTR_W  program memory data at address PC, same cycle.
STALL  in  1  freezes the unit while high.
RESUME  in  1  single-cycle pulse; leaves HALTED.
ACC_ZERO  in  1  accumulator == 0.
ACC_NEG  in  1  accumulator MSB.
PC  out  PC_W  program memory address (register).
OPERAND  out  OPERAND_W  IR operand field (register).
SEL_A  out  2  ACC source: 0 RAM, 1 immediate, 2 ALU.
SEL_B  out  1  ALU B source: 0 RAM, 1 immediate.
OP  out  1  ALU op: 0 add, 1 sub.
WR_ACC, WR_RAM, RD_RAM  out  1 each  datapath strobes.
HALTED  out  1  high in HALTED state.
ILLEGAL  out  1  undefined opcode in valid IR.

Behaviour:
- Interface: reset RESET, asynchronous, active-high; clock CLK.
- Reset values: PC=RESET_VECTOR, IR opcode=0, OPERAND=0, ir_valid=0, state=RUN. All control outputs, HALTED and ILLEGAL are 0.
- States: RUN, HALTED.
- RUN, STALL=0, no redirect: IR<=INSTRUCTION, ir_valid<=1, PC<=PC+1 (modulo 2^PC_W; the max value wraps to 0).
- The decode is combinational from the IR. Outputs are forced to 0 when ir_valid=0, when STALL=1, or in HALTED.
- Opcodes:
  - 00000 HLT: all 0.
  - 00001 STO: WR_RAM.
  - 00010 LD: SEL_A=0, WR_ACC, RD_RAM.
  - 00011 LDI: SEL_A=1, WR_ACC.
  - 00100 ADD: SEL_A=2, SEL_B=0, OP=0, WR_ACC, RD_RAM.
  - 00101 ADDI: SEL_A=2, SEL_B=1, OP=0, WR_ACC.
  - 00110 SUB: as ADD with OP=1.
  - 00111 SUBI: as ADDI with OP=1.
  - 01000 BEQ: taken if ACC_ZERO.
  - 01001 BNE: taken if !ACC_ZERO.
  - 01010 BMI: taken if ACC_NEG.
  - 01011 JMP: always taken.
  - Branches drive all datapath outputs to 0.
  - Any other opcode executes as a NOP with ILLEGAL=1 for that cycle; PC advances normally.
- Branch: taken while in the IR with ir_valid=1 and STALL=0. Then PC<=OPERAND[PC_W-1:0] (absolute target) and ir_valid<=0, which flushes the instruction on the bus. Penalty is 1 bubble cycle. A not-taken branch costs nothing.
- Flags are sampled in the cycle the branch sits in the IR. They reflect all earlier instructions, since the ACC write completes at the end of the previous cycle.
- HLT valid in IR with STALL=0: state<=HALTED, ir_valid<=0, PC holds at (HLT address + 1). HALTED=1 from the next cycle.
- HALTED: PC and IR hold and outputs are 0. RESUME=1 sets state<=RUN, and fetch restarts at the held PC next cycle. RESUME in RUN is ignored.
- STALL=1 in RUN: PC, IR, ir_valid and state all hold. The IR instruction executes exactly once, in the first cycle with STALL=0.
- Precedence: STALL over branch and HLT. In HALTED, RESUME is honoured even if STALL=1.
- RESET mid-operation: immediate return to reset values, including out of HALTED or mid-branch.

Test Plan:
- Reset, program [0]=LDI 5, [1]=ADDI 3, [2]=STO 7, [3]=HLT -> IR cycles give SEL_A=1/WR_ACC, then SEL_A=2/SEL_B=1/OP=0/WR_ACC, then WR_RAM with OPERAND=7. HALTED=1 from cycle 5 with PC=4 held.
- JMP 0x200 at address 10 -> next cycle all outputs 0 (bubble), PC=0x200, then the instruction at 0x200 decodes.
- BEQ 20 at address 4 with ACC_ZERO=0 -> no bubble, PC goes 5, 6. Repeat with ACC_ZERO=1 -> bubble, PC=20.
- STALL high for 3 cycles while ADD is in IR -> PC constant, WR_ACC/RD_RAM=0 during the stall. WR_ACC=1 for exactly one cycle after STALL falls.
- HALTED at PC=4, RESUME pulse -> HALTED=0 next cycle, instruction at address 4 is fetched. RESUME pulsed in RUN has no effect.
- PC_W=4, sequential NOPs from 14 -> PC goes 15, 0, 1. Opcode 11111 -> ILLEGAL=1 for one cycle. RESET asserted mid-stream -> PC=RESET_VECTOR and outputs 0 asynchronously.

Source files
------------

// File: rtl/bip_control_unit_v2.sv
// BIP control unit: PC, registered IR and combinational decode, with branches, HALT/RESUME and STALL.
// A decoded instruction drives the datapath in the cycle it sits in the IR. A taken branch costs one bubble.
module bip_control_unit_v2 #(
  parameter int INSTR_W = 16,
  parameter int PC_W = 11,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0,
  localparam int OPERAND_W = INSTR_W - 5
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [INSTR_W-1:0]   INSTRUCTION,
  input  logic                 STALL,
  input  logic                 RESUME,
  input  logic                 ACC_ZERO,
  input  logic                 ACC_NEG,
  output logic [PC_W-1:0]      PC,
  output logic [OPERAND_W-1:0] OPERAND,
  output logic [1:0]           SEL_A,
  output logic                 SEL_B,
  output logic                 OP,
  output logic                 WR_ACC,
  output logic                 WR_RAM,
  output logic                 RD_RAM,
  output logic                 HALTED,
  output logic                 ILLEGAL
);

  typedef enum logic {S_RUN, S_HALTED} state_t;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;
  localparam logic [4:0] OP_BEQ  = 5'b01000;
  localparam logic [4:0] OP_BNE  = 5'b01001;
  localparam logic [4:0] OP_BMI  = 5'b01010;
  localparam logic [4:0] OP_JMP  = 5'b01011;

  state_t                 state_q, state_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic [4:0]             ir_op_q, ir_op_d;
  logic [OPERAND_W-1:0]   operand_q, operand_d;
  logic                   ir_valid_q, ir_valid_d;
  logic                   exec;
  logic                   taken;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_VECTOR;
      ir_op_q    <= OP_HLT;
      operand_q  <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_op_q    <= ir_op_d;
      operand_q  <= operand_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign exec = (state_q == S_RUN) && ir_valid_q && !STALL;

  always_comb begin
    taken = 1'b0;
    case (ir_op_q)
      OP_BEQ:  taken = ACC_ZERO;
      OP_BNE:  taken = !ACC_ZERO;
      OP_BMI:  taken = ACC_NEG;
      OP_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // HLT and taken branches both drop ir_valid so the word on the bus is never latched.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_op_d    = ir_op_q;
    operand_d  = operand_q;
    ir_valid_d = ir_valid_q;
    case (state_q)
      S_RUN: begin
        if (!STALL) begin
          if (ir_valid_q && ir_op_q == OP_HLT) begin
            state_d    = S_HALTED;
            ir_valid_d = 1'b0;
          end else if (ir_valid_q && taken) begin
            pc_d       = operand_q[PC_W-1:0];
            ir_valid_d = 1'b0;
          end else begin
            ir_op_d    = INSTRUCTION[INSTR_W-1 -: 5];
            operand_d  = INSTRUCTION[OPERAND_W-1:0];
            ir_valid_d = 1'b1;
            pc_d       = pc_q + PC_W'(1);
          end
        end
      end
      S_HALTED: begin
        if (RESUME) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    SEL_A   = 2'd0;
    SEL_B   = 1'b0;
    OP      = 1'b0;
    WR_ACC  = 1'b0;
    WR_RAM  = 1'b0;
    RD_RAM  = 1'b0;
    ILLEGAL = 1'b0;
    if (exec) begin
      case (ir_op_q)
        OP_HLT: ;
        OP_STO: WR_RAM = 1'b1;
        OP_LD: begin
          WR_ACC = 1'b1;
          RD_RAM = 1'b1;
        end
        OP_LDI: begin
          SEL_A  = 2'd1;
          WR_ACC = 1'b1;
        end
        OP_ADD, OP_SUB: begin
          SEL_A  = 2'd2;
          OP     = (ir_op_q == OP_SUB);
          WR_ACC = 1'b1;
          RD_RAM = 1'b1;
        end
        OP_ADDI, OP_SUBI: begin
          SEL_A  = 2'd2;
          SEL_B  = 1'b1;
          OP     = (ir_op_q == OP_SUBI);
          WR_ACC = 1'b1;
        end
        OP_BEQ, OP_BNE, OP_BMI, OP_JMP: ;
        default: ILLEGAL = 1'b1;
      endcase
    end
  end

  assign PC      = pc_q;
  assign OPERAND = operand_q;
  assign HALTED  = (state_q == S_HALTED);

endmodule
